// File: rtl/hilo_muldiv_pkg.sv
// Shared CPU definitions for the HI/LO multiply/divide unit.
// Holds the op encodings (also decoded by the control unit), the FSM state
// encoding and the iteration count used by the iterative datapath.
package hilo_muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } muldiv_state_e;

    // Counter is 6 bits so the value 32 (last iteration) is representable.
    localparam int CNT_W = 6;
    localparam logic [CNT_W-1:0] MULDIV_ITERS = 6'd32;

endpackage

// File: rtl/hilo_muldiv.sv
// Iterative multiply/divide unit producing the {HI, LO} pair.
//
// Ports:
//   clk                - rising-edge clock
//   rst                - synchronous active-high reset
//   start              - request an operation (only looked at in IDLE)
//   op                 - 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src_a / src_b      - multiplicand/dividend and multiplier/divisor
//   cancel             - flush: abort the operation without writing HI/LO
//   busy               - high whenever the FSM is not IDLE (stall request)
//   HI_LO_data         - {HI, LO}; product, or {remainder, quotient}
//   HI_LO_write_enable - one-cycle pulse in DONE marking HI_LO_data valid
//   div_by_zero        - set with the result when a divide had a zero divisor
//
// Timing: the accepting edge k enters CALC. The first CALC cycle (counter 0)
// loads operand magnitudes into the working register, then 32 cycles each
// perform one iteration (counter 1..32). FIX applies sign correction, and
// DONE is entered at edge k+34, so busy is high for 35 cycles.
module hilo_muldiv
    import hilo_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [WIDTH-1:0]     src_a,
    input  logic [WIDTH-1:0]     src_b,
    input  logic                 cancel,
    output logic                 busy,
    output logic [2*WIDTH-1:0]   HI_LO_data,
    output logic                 HI_LO_write_enable,
    output logic                 div_by_zero
);

    localparam int W2 = 2 * WIDTH;

    muldiv_state_e      state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    muldiv_op_e         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [W2-1:0]      acc_q, acc_d;
    logic [W2-1:0]      hi_lo_q, hi_lo_d;
    logic               dbz_q, dbz_d;

    logic               is_mul;
    logic               is_signed;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     add_x;
    logic [WIDTH:0]     add_y;
    logic               add_cin;
    logic [WIDTH+1:0]   add_sum;
    logic [W2-1:0]      iter_next;
    logic [W2-1:0]      fix_val;
    logic               fix_dbz;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    // Operand decode and magnitudes of the latched operands
    always_comb begin
        is_mul    = (op_q == OP_MULT) || (op_q == OP_MULTU);
        is_signed = (op_q == OP_MULT) || (op_q == OP_DIV);
        a_neg     = is_signed && a_q[WIDTH-1];
        b_neg     = is_signed && b_q[WIDTH-1];
        a_mag     = a_neg ? -a_q : a_q;
        b_mag     = b_neg ? -b_q : b_q;
    end

    // Single shared adder.
    // Multiply: HI + multiplicand, carry kept in bit WIDTH.
    // Divide:   (shifted remainder) - divisor; bit WIDTH+1 set means no borrow.
    always_comb begin
        if (is_mul) begin
            add_x   = {1'b0, acc_q[W2-1:WIDTH]};
            add_y   = {1'b0, opnd_q};
            add_cin = 1'b0;
        end else begin
            add_x   = acc_q[W2-1:WIDTH-1];
            add_y   = ~{1'b0, opnd_q};
            add_cin = 1'b1;
        end
        add_sum = {1'b0, add_x} + {1'b0, add_y} + {{(WIDTH+1){1'b0}}, add_cin};
    end

    // One iteration of shift-add multiply or restoring divide on acc_q
    always_comb begin
        if (is_mul) begin
            if (acc_q[0]) begin
                iter_next = {add_sum[WIDTH:0], acc_q[WIDTH-1:1]};
            end else begin
                iter_next = {1'b0, acc_q[W2-1:1]};
            end
        end else begin
            if (add_sum[WIDTH+1]) begin
                iter_next = {add_sum[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
                iter_next = {acc_q[W2-2:0], 1'b0};
            end
        end
    end

    // Sign correction and the zero-divisor override
    always_comb begin
        quo     = acc_q[WIDTH-1:0];
        rem     = acc_q[W2-1:WIDTH];
        fix_dbz = 1'b0;
        if (is_mul) begin
            fix_val = (a_neg ^ b_neg) ? -acc_q : acc_q;
        end else if (b_q == '0) begin
            fix_val = {a_q, {WIDTH{1'b1}}};
            fix_dbz = 1'b1;
        end else begin
            // MIN / -1 wraps naturally: negating 0x80000000 gives itself.
            fix_val = {(a_neg ? -rem : rem), ((a_neg ^ b_neg) ? -quo : quo)};
        end
    end

    // Next-state and datapath register updates
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        opnd_d  = opnd_q;
        acc_d   = acc_q;
        hi_lo_d = hi_lo_q;
        dbz_d   = dbz_q;

        case (state_q)
            ST_IDLE: begin
                // cancel wins over start: a flushed instruction is not accepted
                if (start && !cancel) begin
                    state_d = ST_CALC;
                    cnt_d   = '0;
                    op_d    = muldiv_op_e'(op);
                    a_d     = src_a;
                    b_d     = src_b;
                    dbz_d   = 1'b0;
                end
            end
            ST_CALC: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    // Load phase: multiplier (or dividend) in LO, HI cleared
                    opnd_d = is_mul ? a_mag : b_mag;
                    acc_d  = {{WIDTH{1'b0}}, (is_mul ? b_mag : a_mag)};
                    cnt_d  = cnt_q + 1'b1;
                end else begin
                    acc_d = iter_next;
                    if (cnt_q == MULDIV_ITERS) begin
                        state_d = ST_FIX;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_FIX: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                    hi_lo_d = fix_val;
                    dbz_d   = fix_dbz;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_lo_q <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_lo_q <= hi_lo_d;
            dbz_q   <= dbz_d;
        end
    end

    // Working datapath registers; only meaningful while an operation runs
    always_ff @(posedge clk) begin
        op_q   <= op_d;
        a_q    <= a_d;
        b_q    <= b_d;
        opnd_q <= opnd_d;
        acc_q  <= acc_d;
    end

    assign busy               = (state_q != ST_IDLE);
    // A flush arriving in DONE still suppresses the write
    assign HI_LO_write_enable = (state_q == ST_DONE) && !cancel;
    assign HI_LO_data         = hi_lo_q;
    assign div_by_zero        = dbz_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed bench for hilo_muldiv: a vector table of operations with
// hand-computed {HI, LO} results, plus sequences for reset, cancel and
// start/cancel interaction.
module tb_hilo_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        cancel;
    logic        busy;
    logic [63:0] HI_LO_data;
    logic        HI_LO_write_enable;
    logic        div_by_zero;

    int checks   = 0;
    int failures = 0;

    hilo_muldiv #(.WIDTH(32)) dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .op                 (op),
        .src_a              (src_a),
        .src_b              (src_b),
        .cancel             (cancel),
        .busy               (busy),
        .HI_LO_data         (HI_LO_data),
        .HI_LO_write_enable (HI_LO_write_enable),
        .div_by_zero        (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Observe 40 cycles after an accepting edge (called #1 after that edge).
    task automatic collect(output logic [63:0] data, output logic dbz, output int we_cyc,
                           output int we_cnt, output int busy_cnt, output logic [63:0] data_late);
        we_cyc   = -1;
        we_cnt   = 0;
        busy_cnt = 0;
        data     = '0;
        dbz      = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (HI_LO_write_enable) begin
                we_cnt++;
                we_cyc = n;
                data   = HI_LO_data;
                dbz    = div_by_zero;
            end
        end
        data_late = HI_LO_data;
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [63:0] data, output logic dbz, output int we_cyc,
                          output int we_cnt, output int busy_cnt, output logic [63:0] data_late);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        @(posedge clk);
        #1 start = 1'b0;
        collect(data, dbz, we_cyc, we_cnt, busy_cnt, data_late);
    endtask

    initial begin
        logic [63:0] data;
        logic [63:0] data_late;
        logic        dbz;
        int          we_cyc;
        int          we_cnt;
        int          busy_cnt;
        int          we_seen;

        vecs[0]  = '{"multu_max",   2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[1]  = '{"mult_neg",    2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
        vecs[2]  = '{"div_neg",     2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[3]  = '{"divu_zero",   2'b11, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 1'b1};
        vecs[4]  = '{"div_ovf",     2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[5]  = '{"multu_shift", 2'b01, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};
        vecs[6]  = '{"mult_min",    2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[7]  = '{"mult_m1m1",   2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
        vecs[8]  = '{"divu_100_7",  2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
        vecs[9]  = '{"div_7_m2",    2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[10] = '{"div_zero",    2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
        vecs[11] = '{"divu_by1",    2'b11, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0};
        vecs[12] = '{"divu_big",    2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0};
        vecs[13] = '{"multu_zero",  2'b01, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b0};

        rst    = 1'b1;
        start  = 1'b0;
        cancel = 1'b0;
        op     = 2'b00;
        src_a  = '0;
        src_b  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_we",   {63'd0, HI_LO_write_enable}, 64'd0);
        check("reset_data", HI_LO_data, 64'd0);
        check("reset_dbz",  {63'd0, div_by_zero}, 64'd0);
        rst = 1'b0;

        // Cancel has priority over start in IDLE
        @(negedge clk);
        start  = 1'b1;
        cancel = 1'b1;
        op     = 2'b01;
        src_a  = 32'd3;
        src_b  = 32'd4;
        @(negedge clk);
        check("cancel_start_idle_busy", {63'd0, busy}, 64'd0);
        start  = 1'b0;
        cancel = 1'b0;

        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, data, dbz, we_cyc, we_cnt, busy_cnt, data_late);
            check({vecs[i].name, "_data"},   data, {vecs[i].hi, vecs[i].lo});
            check({vecs[i].name, "_dbz"},    {63'd0, dbz}, {63'd0, vecs[i].dbz});
            check({vecs[i].name, "_we_cyc"}, 64'(we_cyc), 64'd34);
            check({vecs[i].name, "_we_cnt"}, 64'(we_cnt), 64'd1);
            check({vecs[i].name, "_busy"},   64'(busy_cnt), 64'd35);
            check({vecs[i].name, "_stable"}, data_late, {vecs[i].hi, vecs[i].lo});
        end

        // Cancel 10 cycles after acceptance with start still held high
        @(negedge clk);
        start = 1'b1;
        op    = 2'b01;
        src_a = 32'd7;
        src_b = 32'd3;
        @(posedge clk);
        we_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (HI_LO_write_enable) we_seen++;
            if (i == 9) begin
                check("cancel_busy_before", {63'd0, busy}, 64'd1);
                cancel = 1'b1;
            end
        end
        @(negedge clk);
        if (HI_LO_write_enable) we_seen++;
        check("cancel_busy_after", {63'd0, busy}, 64'd0);
        check("cancel_no_write", 64'(we_seen), 64'd0);
        cancel = 1'b0;
        op     = 2'b11;
        src_a  = 32'd100;
        src_b  = 32'd7;
        @(posedge clk);
        #1 start = 1'b0;
        collect(data, dbz, we_cyc, we_cnt, busy_cnt, data_late);
        check("after_cancel_data",   data, {32'd2, 32'd14});
        check("after_cancel_we_cyc", 64'(we_cyc), 64'd34);
        check("after_cancel_busy",   64'(busy_cnt), 64'd35);

        // Reset in the middle of an operation discards it
        @(negedge clk);
        start = 1'b1;
        op    = 2'b01;
        src_a = 32'd5;
        src_b = 32'd5;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_data", HI_LO_data, 64'd0);
        rst = 1'b0;
        collect(data, dbz, we_cyc, we_cnt, busy_cnt, data_late);
        check("midrst_no_write", 64'(we_cnt), 64'd0);
        check("midrst_idle",     64'(busy_cnt), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
